// File: rtl/div_if.sv
// Request/response bundle between the exe stage and the iterative divider.
interface div_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                  start_i;
    logic                  signed_i;
    logic                  rem_i;
    logic [DATA_WIDTH-1:0] dividend_i;
    logic [DATA_WIDTH-1:0] divisor_i;
    logic                  annul_i;
    logic                  busy_o;
    logic                  done_o;
    logic [DATA_WIDTH-1:0] result_o;

    // exe side: issues requests, watches the stall and result
    modport master (
        output start_i,
        output signed_i,
        output rem_i,
        output dividend_i,
        output divisor_i,
        output annul_i,
        input  busy_o,
        input  done_o,
        input  result_o
    );

    // divider side
    modport slave (
        input  start_i,
        input  signed_i,
        input  rem_i,
        input  dividend_i,
        input  divisor_i,
        input  annul_i,
        output busy_o,
        output done_o,
        output result_o
    );

endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the loop.
module div_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic   clk_i,
    input logic   rst_i,
    div_if.slave  bus
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     rem_q;
    logic [W-1:0]     quo_q;
    logic [W-1:0]     dvsr_q;
    logic [W-1:0]     result_q;
    logic             done_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             rem_sel_q;
    logic             div0_q;
    logic             ovf_q;

    logic             accept_c;
    logic             dvd_neg_c;
    logic             dvs_neg_c;
    logic [W-1:0]     dvd_mag_c;
    logic [W-1:0]     dvs_mag_c;
    logic             div0_c;
    logic             ovf_c;
    logic [W:0]       shifted_c;
    logic [W:0]       trial_c;
    logic [W-1:0]     rem_d;
    logic [W-1:0]     quo_d;
    logic [W-1:0]     quo_fix_c;
    logic [W-1:0]     rem_fix_c;
    logic [W-1:0]     result_d;

    // Acceptance is blocked during the done cycle so a still-held start does not re-trigger
    assign accept_c = (state_q == IDLE) && bus.start_i && !bus.annul_i && !done_q;

    assign bus.busy_o   = accept_c || (state_q == CALC) || (state_q == FIX);
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;

    // Operand classification and magnitudes
    always_comb begin
        dvd_neg_c = bus.signed_i && bus.dividend_i[W-1];
        dvs_neg_c = bus.signed_i && bus.divisor_i[W-1];
        dvd_mag_c = dvd_neg_c ? (~bus.dividend_i + W'(1)) : bus.dividend_i;
        dvs_mag_c = dvs_neg_c ? (~bus.divisor_i + W'(1)) : bus.divisor_i;
        div0_c    = (bus.divisor_i == '0);
        ovf_c     = bus.signed_i
                    && (bus.dividend_i == {1'b1, {(W-1){1'b0}}})
                    && (bus.divisor_i == '1);
    end

    // One restoring step; rem < divisor keeps the trial within W+1 signed bits
    always_comb begin
        shifted_c = {rem_q, quo_q[W-1]};
        trial_c   = shifted_c - {1'b0, dvsr_q};
        rem_d     = trial_c[W] ? shifted_c[W-1:0] : trial_c[W-1:0];
        quo_d     = {quo_q[W-2:0], ~trial_c[W]};
    end

    // Sign correction and special-case selection; in the fast path quo_q holds the raw dividend
    always_comb begin
        quo_fix_c = neg_quo_q ? (~quo_q + W'(1)) : quo_q;
        rem_fix_c = neg_rem_q ? (~rem_q + W'(1)) : rem_q;
        result_d  = rem_sel_q ? rem_fix_c : quo_fix_c;
        if (div0_q) begin
            result_d = rem_sel_q ? quo_q : '1;
        end else if (ovf_q) begin
            result_d = rem_sel_q ? '0 : {1'b1, {(W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_sel_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        rem_sel_q <= bus.rem_i;
                        neg_quo_q <= dvd_neg_c ^ dvs_neg_c;
                        neg_rem_q <= dvd_neg_c;
                        div0_q    <= div0_c;
                        ovf_q     <= ovf_c;
                        if (div0_c || ovf_c) begin
                            quo_q   <= bus.dividend_i;
                            state_q <= FIX;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= dvd_mag_c;
                            dvsr_q  <= dvs_mag_c;
                            cnt_q   <= CNT_W'(W);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.annul_i) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    if (!bus.annul_i) begin
                        result_q <= result_d;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors push expected results,
// a negedge monitor pops one entry per done_o pulse.
module tb_div_unit;

    localparam int unsigned W = 32;

    logic clk;
    logic rst_n;

    div_if #(.DATA_WIDTH(W)) bus ();

    div_unit #(.DATA_WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] sb_q [$];
    logic [W-1:0] last_result;
    int           n_checks;
    int           n_fails;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done_o pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && bus.done_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [W-1:0] exp_v;
                exp_v = sb_q.pop_front();
                check("result", bus.result_o, exp_v);
            end
        end
    end

    // Caller is at posedge+1; returns at posedge+1 just after the done cycle
    task automatic run_op(input string name, input logic s, input logic r,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input int exp_busy, input logic hold);
        int  busy_cnt;
        logic seen;
        bus.start_i    = 1'b1;
        bus.signed_i   = s;
        bus.rem_i      = r;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        sb_q.push_back(exp);
        last_result = exp;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) seen = 1'b1;
            else if (bus.busy_o === 1'b1) busy_cnt++;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check({name, "_busy_in_done"}, 32'(bus.busy_o), 32'd0);
        @(posedge clk); #1;
        if (!hold) bus.start_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fails        = 0;
        last_result    = '0;
        rst_n          = 1'b0;
        bus.start_i    = 1'b0;
        bus.signed_i   = 1'b0;
        bus.rem_i      = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        bus.annul_i    = 1'b0;
        idle(3);
        @(negedge clk);
        check("reset_done", 32'(bus.done_o), 32'd0);
        check("reset_busy", 32'(bus.busy_o), 32'd0);
        check("reset_result", bus.result_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Normal path: 34 busy cycles
        run_op("divu_100_7", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 34, 1'b0);
        idle(3);
        run_op("remu_100_7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 34, 1'b0);
        idle(2);
        run_op("div_m7_2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0);
        idle(2);
        run_op("rem_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0);
        idle(2);
        run_op("div_7_m2", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 1'b0);
        idle(2);
        run_op("rem_7_m2", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 1'b0);
        idle(2);
        run_op("divu_max_1", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 1'b0);
        idle(2);
        run_op("divu_min_m1", 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 1'b0);
        idle(2);
        run_op("div_min_1", 1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 34, 1'b0);
        idle(2);

        // Fast path: 2 busy cycles (request cycle + FIX)
        run_op("divu_5_0", 1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
        idle(2);
        run_op("remu_5_0", 1'b0, 1'b1, 32'd5, 32'd0, 32'd5, 2, 1'b0);
        idle(2);
        run_op("rem_m5_0", 1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 2, 1'b0);
        idle(2);
        run_op("div_ovf", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b0);
        idle(2);
        run_op("rem_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, 1'b0);
        idle(2);

        // Annul after 10 CALC edges: no done, result held
        bus.start_i    = 1'b1;
        bus.signed_i   = 1'b0;
        bus.rem_i      = 1'b0;
        bus.dividend_i = 32'd1000;
        bus.divisor_i  = 32'd3;
        idle(11);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        idle(1);
        bus.annul_i = 1'b0;
        @(negedge clk);
        check("annul_busy", 32'(bus.busy_o), 32'd0);
        check("annul_result_held", bus.result_o, last_result);
        idle(40);
        run_op("divu_9_3", 1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 34, 1'b0);
        idle(2);

        // annul together with start in IDLE starts nothing
        bus.start_i    = 1'b1;
        bus.annul_i    = 1'b1;
        @(negedge clk);
        check("annul_start_busy", 32'(bus.busy_o), 32'd0);
        idle(1);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        @(negedge clk);
        check("annul_start_idle", 32'(bus.busy_o), 32'd0);
        idle(3);

        // Synchronous reset mid-CALC
        bus.start_i    = 1'b1;
        bus.dividend_i = 32'd77;
        bus.divisor_i  = 32'd5;
        idle(6);
        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        idle(1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_done", 32'(bus.done_o), 32'd0);
        check("rst_mid_busy", 32'(bus.busy_o), 32'd0);
        check("rst_mid_result", bus.result_o, 32'd0);
        idle(40);

        // start held through done, then new operands accepted right after
        run_op("divu_20_6_hold", 1'b0, 1'b0, 32'd20, 32'd6, 32'd3, 34, 1'b1);
        run_op("remu_20_6_b2b", 1'b0, 1'b1, 32'd20, 32'd6, 32'd2, 34, 1'b0);
        idle(40);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
